// File: rtl/bullet_sprite_drawer_pkg.sv
// Shared constants, palette and slot type for the bullet sprite drawer.
// BULLET_BBOX_EN (optional) adds a magenta bounding-box overlay in the top module.
package bullet_pkg;

    localparam int SPRITE_W     = 7;
    localparam int SPRITE_H     = 25;
    localparam int SPRITE_DEPTH = SPRITE_W * SPRITE_H;

    // Packed so element 0 is the rightmost entry; index 0 is the transparent colour
    localparam logic [7:0][23:0] PALETTE = {
        24'h00FFFF, 24'hC0C0C0, 24'h808080, 24'hFF0000,
        24'hFF8000, 24'hFFFF00, 24'hFFFFFF, 24'h000000
    };

    localparam logic [23:0] BBOX_RGB = 24'hFF00FF;

    typedef struct packed {
        logic       active;
        logic [9:0] x;
        logic [9:0] y;
    } bullet_slot_t;

    function automatic logic [7:0] sprite_addr(input logic [4:0] row, input logic [2:0] col);
        return ({3'b000, row} * 8'd7) + {5'b00000, col};
    endfunction

endpackage

// File: rtl/bullet_sprite_drawer_if.sv
// Fire handshake, pixel coordinates and sprite RAM / colour-mapper signals.
interface bullet_sprite_drawer_if;
    logic        fire_valid;
    logic        fire_ready;
    logic [9:0]  fire_x;
    logic [9:0]  fire_y;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [18:0] read_address;
    logic [4:0]  sprite_data;
    logic        bullet_on;
    logic [23:0] bullet_rgb;
    logic [3:0]  active_count;

    modport slave (
        input  fire_valid, fire_x, fire_y, DrawX, DrawY, sprite_data,
        output fire_ready, read_address, bullet_on, bullet_rgb, active_count
    );

    modport master (
        output fire_valid, fire_x, fire_y, DrawX, DrawY, sprite_data,
        input  fire_ready, read_address, bullet_on, bullet_rgb, active_count
    );
endinterface

// File: rtl/bullet_sprite_drawer_frame_tick_sync.sv
// Brings the asynchronous vsync level into the Clk domain and emits a
// one-cycle tick on its rising edge.
module frame_tick_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic tick_o
);
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick_o = sync2_q & ~prev_q;
endmodule

// File: rtl/bullet_sprite_drawer.sv
// Bullet slot manager plus 2-stage pixel path in front of/behind frameRAM_Bullet.
// Optional BULLET_BBOX_EN: paint the sprite bounding-box border in BBOX_RGB.
module bullet_sprite_drawer
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int SPEED       = 4,
    parameter int SCREEN_H    = 480
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   frame_clk,
    bullet_sprite_drawer_if.slave  bus
);
    localparam int          IDX_W      = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam logic [9:0]  SPEED_V    = 10'(SPEED);
    localparam logic [10:0] SCREEN_H_V = 11'(SCREEN_H);
    localparam logic [9:0]  LAST_COL   = 10'(SPRITE_W - 1);
    localparam logic [9:0]  LAST_ROW   = 10'(SPRITE_H - 1);

    bullet_slot_t            slots_q [NUM_BULLETS];
    bullet_slot_t            slots_d [NUM_BULLETS];
    logic [3:0]              active_count_q, active_count_d;
    logic [NUM_BULLETS-1:0]  free_map;
    logic [IDX_W-1:0]        alloc_idx;
    logic                    fire_accept;
    logic                    tick;

    frame_tick_sync u_tick (
        .clk_i   (Clk),
        .rst_n_i (Reset_n),
        .async_i (frame_clk),
        .tick_o  (tick)
    );

    // ---------------- slot allocation and motion ----------------
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (free_map[i]) alloc_idx = IDX_W'(i);
        end
    end

    // Free map is taken before the tick, so a slot vacated by a tick is offered next cycle
    assign bus.fire_ready = (|free_map) && ({1'b0, bus.fire_y} < SCREEN_H_V);
    assign fire_accept    = bus.fire_valid && bus.fire_ready;

    always_comb begin
        for (int i = 0; i < NUM_BULLETS; i++) begin
            slots_d[i] = slots_q[i];
            if (tick && slots_q[i].active) begin
                if (slots_q[i].y >= SPEED_V) slots_d[i].y      = slots_q[i].y - SPEED_V;
                else                         slots_d[i].active = 1'b0;
            end
            if (fire_accept && (IDX_W'(i) == alloc_idx)) begin
                slots_d[i].active = 1'b1;
                slots_d[i].x      = bus.fire_x;
                slots_d[i].y      = bus.fire_y;
            end
        end
    end

    always_comb begin
        active_count_d = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            active_count_d = active_count_d + {3'b000, slots_d[i].active};
        end
    end

    // ---------------- stage 0: hit test and RAM address ----------------
    logic [10:0]            dx [NUM_BULLETS];
    logic [10:0]            dy [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] hit_vec;

    generate
        for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
            assign free_map[gi] = ~slots_q[gi].active;
            assign dx[gi]       = {1'b0, bus.DrawX} - {1'b0, slots_q[gi].x};
            assign dy[gi]       = {1'b0, bus.DrawY} - {1'b0, slots_q[gi].y};
            // Bit 10 is the borrow: pixel left of / above the sprite
            assign hit_vec[gi]  = slots_q[gi].active
                                && !dx[gi][10] && (dx[gi][9:0] <= LAST_COL)
                                && !dy[gi][10] && (dy[gi][9:0] <= LAST_ROW);
        end
    endgenerate

    logic       hit_s0;
    logic [4:0] row_s0;
    logic [2:0] col_s0;

    always_comb begin
        hit_s0 = 1'b0;
        row_s0 = '0;
        col_s0 = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_s0 = 1'b1;
                row_s0 = dy[i][4:0];
                col_s0 = dx[i][2:0];
            end
        end
    end

    assign bus.read_address = hit_s0 ? {11'b0, sprite_addr(row_s0, col_s0)} : '0;

    // ---------------- stages 1 and 2 ----------------
    logic        hit_d1_q;
    logic        bullet_on_q, bullet_on_d;
    logic [23:0] bullet_rgb_q, bullet_rgb_d;
    logic [2:0]  pix_idx;
    logic        unused_sprite_bits;

    assign pix_idx            = bus.sprite_data[2:0];
    assign unused_sprite_bits = ^bus.sprite_data[4:3];

`ifdef BULLET_BBOX_EN
    logic border_s0, border_d1_q;

    assign border_s0 = hit_s0 && ((col_s0 == 3'd0) || (col_s0 == 3'(SPRITE_W - 1)) ||
                                  (row_s0 == 5'd0) || (row_s0 == 5'(SPRITE_H - 1)));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) border_d1_q <= 1'b0;
        else          border_d1_q <= border_s0;
    end

    always_comb begin
        bullet_on_d  = hit_d1_q && (border_d1_q || (pix_idx != 3'd0));
        bullet_rgb_d = '0;
        if (hit_d1_q && border_d1_q) bullet_rgb_d = BBOX_RGB;
        else if (bullet_on_d)        bullet_rgb_d = PALETTE[pix_idx];
    end
`else
    always_comb begin
        bullet_on_d  = hit_d1_q && (pix_idx != 3'd0);
        bullet_rgb_d = bullet_on_d ? PALETTE[pix_idx] : '0;
    end
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_BULLETS; i++) slots_q[i] <= '0;
            active_count_q <= '0;
            hit_d1_q       <= 1'b0;
            bullet_on_q    <= 1'b0;
            bullet_rgb_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_BULLETS; i++) slots_q[i] <= slots_d[i];
            active_count_q <= active_count_d;
            hit_d1_q       <= hit_s0;
            bullet_on_q    <= bullet_on_d;
            bullet_rgb_q   <= bullet_rgb_d;
        end
    end

    assign bus.bullet_on    = bullet_on_q;
    assign bus.bullet_rgb   = bullet_rgb_q;
    assign bus.active_count = active_count_q;

endmodule

// File: tb/tb_bullet_sprite_drawer.sv
// Self-checking bench: hand tables for the pixel boundaries, directed
// multi-cycle sequences and a randomized run against a slot-list model.
module tb_bullet_sprite_drawer;
    localparam int NB  = 4;
    localparam int SPD = 4;
    localparam int SH  = 480;
`ifdef BULLET_BBOX_EN
    localparam bit BBOX = 1'b1;
`else
    localparam bit BBOX = 1'b0;
`endif
    localparam logic [23:0] PAL [8] = '{24'h000000, 24'hFFFFFF, 24'hFFFF00, 24'hFF8000,
                                        24'hFF0000, 24'h808080, 24'hC0C0C0, 24'h00FFFF};

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic frame_clk = 1'b0;

    bullet_sprite_drawer_if bus ();

    bullet_sprite_drawer #(.NUM_BULLETS(NB), .SPEED(SPD), .SCREEN_H(SH)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    always #5 Clk = ~Clk;

    // Sprite RAM model: one cycle read latency, junk in the unused upper bits
    logic [2:0] ram [256];
    always @(posedge Clk) begin
        bus.sprite_data <= (bus.read_address < 19'd175)
                         ? {2'($urandom_range(0, 3)), ram[bus.read_address[7:0]]} : 5'd0;
    end

    // Reference model: a plain list of bullets
    bit m_act [NB];
    int m_x   [NB];
    int m_y   [NB];

    int total = 0;
    int bad   = 0;
    int acc   = 0;

    typedef struct { bit on; logic [23:0] rgb; } pexp_t;
    pexp_t pq [$];

    typedef struct { int dx; int dy; int addr; } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NB; i++) n += m_act[i] ? 1 : 0;
        return n;
    endfunction

    function automatic bit m_ready(input int fy);
        return (m_count() < NB) && (fy < SH);
    endfunction

    function automatic void m_lookup(input int px, input int py,
                                     output bit hit, output int addr, output bit border);
        hit = 0; addr = 0; border = 0;
        for (int i = 0; i < NB; i++) begin
            int ddx = px - m_x[i];
            int ddy = py - m_y[i];
            if (!hit && m_act[i] && ddx >= 0 && ddx <= 6 && ddy >= 0 && ddy <= 24) begin
                hit    = 1;
                addr   = ddy * 7 + ddx;
                border = (ddx == 0) || (ddx == 6) || (ddy == 0) || (ddy == 24);
            end
        end
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < NB; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
    endfunction

    // One clock: checks fire_ready before the edge, active_count after it
    task automatic cyc(input bit tick);
        bit fv, rdy;
        int fx, fy, a;
        #1;
        fx  = int'(bus.fire_x);
        fy  = int'(bus.fire_y);
        fv  = bus.fire_valid;
        rdy = m_ready(fy);
        chk("fire_ready", bus.fire_ready, rdy);
        if (fv && bus.fire_ready) acc++;
        @(posedge Clk);
        a = -1;
        if (fv && rdy)
            for (int i = NB - 1; i >= 0; i--) if (!m_act[i]) a = i;
        if (tick)
            for (int i = 0; i < NB; i++)
                if (m_act[i]) begin
                    if (m_y[i] >= SPD) m_y[i] -= SPD;
                    else               m_act[i] = 0;
                end
        if (a >= 0) begin
            m_act[a] = 1; m_x[a] = fx; m_y[a] = fy;
        end
        #1;
        chk("active_count", bus.active_count, m_count());
    endtask

    task automatic fire1(input int fx, input int fy);
        bus.fire_valid = 1'b1;
        bus.fire_x = 10'(fx);
        bus.fire_y = 10'(fy);
        cyc(0);
        bus.fire_valid = 1'b0;
    endtask

    // frame_clk rises; the tick lands on the third Clk edge
    task automatic frame_tick(input bit f, input int fx, input int fy);
        frame_clk = 1'b1;
        cyc(0);
        cyc(0);
        if (f) begin
            bus.fire_valid = 1'b1;
            bus.fire_x = 10'(fx);
            bus.fire_y = 10'(fy);
        end
        cyc(1);
        bus.fire_valid = 1'b0;
        frame_clk = 1'b0;
        cyc(0);
        cyc(0);
    endtask

    task automatic check_out();
        pexp_t e = pq.pop_front();
        chk("bullet_on", bus.bullet_on, e.on);
        chk("bullet_rgb", bus.bullet_rgb, e.rgb);
    endtask

    // Streams one pixel per cycle; outputs compared two edges after presentation
    task automatic pix(input int px, input int py);
        bit hit, border;
        int addr;
        logic [2:0] idx;
        pexp_t e;
        bus.DrawX = 10'(px);
        bus.DrawY = 10'(py);
        #1;
        m_lookup(px & 1023, py & 1023, hit, addr, border);
        chk("read_address", 32'(bus.read_address), 32'(addr));
        idx = ram[addr];
        if (hit && BBOX && border) begin
            e.on = 1; e.rgb = 24'hFF00FF;
        end else begin
            e.on  = hit && (idx != 3'd0);
            e.rgb = e.on ? PAL[idx] : 24'h0;
        end
        pq.push_back(e);
        cyc(0);
        if (pq.size() >= 2) check_out();
    endtask

    task automatic pix_flush();
        cyc(0);
        while (pq.size() > 0) check_out();
    endtask

    task automatic do_reset();
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst_async_count", bus.active_count, 0);
        chk("rst_async_on", bus.bullet_on, 0);
        m_clear();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        #1;
        chk("rst_fire_ready", bus.fire_ready, 1);
        chk("rst_count", bus.active_count, 0);
        chk("rst_rgb", bus.bullet_rgb, 0);
    endtask

    initial begin
        bus.fire_valid = 1'b0; bus.fire_x = '0; bus.fire_y = '0;
        bus.DrawX = '0; bus.DrawY = '0;
        for (int i = 0; i < 256; i++) ram[i] = 3'd0;
        m_clear();

        tbl[0] = '{103, 210, 73};
        tbl[1] = '{ 99, 210,  0};
        tbl[2] = '{107, 210,  0};
        tbl[3] = '{100, 225,  0};
        tbl[4] = '{106, 224, 174};
        tbl[5] = '{100, 200,  0};
        tbl[6] = '{106, 200,  6};
        tbl[7] = '{100, 199,  0};

        // Power-on reset
        repeat (3) @(posedge Clk);
        #1;
        chk("por_count", bus.active_count, 0);
        chk("por_on", bus.bullet_on, 0);
        chk("por_rgb", bus.bullet_rgb, 0);
        Reset_n = 1'b1;
        #1;
        chk("por_fire_ready", bus.fire_ready, 1);

        // Fill all slots with fire_valid held
        acc = 0;
        bus.fire_valid = 1'b1; bus.fire_x = 10'd100; bus.fire_y = 10'd200;
        repeat (6) cyc(0);
        chk("fill_accepts", acc, NB);
        chk("fill_ready_low", bus.fire_ready, 0);
        bus.fire_valid = 1'b0;

        // Pixel boundaries around the bullet at (100,200)
        ram[73] = 3'd3; ram[174] = 3'd5; ram[6] = 3'd7;
        for (int i = 0; i < 8; i++) begin
            bus.DrawX = 10'(tbl[i].dx);
            bus.DrawY = 10'(tbl[i].dy);
            #1;
            chk("tbl_addr", 32'(bus.read_address), 32'(tbl[i].addr));
            pix(tbl[i].dx, tbl[i].dy);
        end
        pix_flush();
        ram[73] = 3'd0;
        pix(103, 210);
        pix_flush();

        // Overlap: lower index wins, then reset with two live bullets
        do_reset();
        fire1(100, 200);
        fire1(102, 205);
        ram[73] = 3'd2;
        pix(103, 210);
        pix(102, 205);
        pix_flush();
        chk("ovl_count", bus.active_count, 2);
        do_reset();

        // Motion and exit through the top
        fire1(50, 10);
        for (int t = 0; t < 3; t++) begin
            frame_tick(0, 0, 0);
            pix(51, 7 - 4 * t);
            pix(51, 6 - 4 * t);
            pix_flush();
        end
        chk("exit_count", bus.active_count, 0);

        // Fire on the tick cycle: new bullet unmoved, existing one moves
        fire1(200, 50);
        frame_tick(1, 300, 300);
        pix(301, 301);
        pix(201, 47);
        pix(201, 46);
        pix_flush();

        // Full map: slot freed by a tick is offered only on the next cycle
        fire1(10, 2);
        fire1(20, 400);
        bus.fire_y = 10'd480;
        #1;
        chk("reject_y480", bus.fire_ready, 0);
        frame_tick(1, 30, 100);
        fire1(40, 100);

        // Randomized run
        do_reset();
        for (int i = 0; i < 256; i++) ram[i] = 3'($urandom_range(0, 7));
        for (int it = 0; it < 400; it++) begin
            int r = int'($urandom_range(0, 9));
            if (r < 4) begin
                fire1(int'($urandom_range(0, 639)), int'($urandom_range(0, 519)));
            end else if (r == 4) begin
                frame_tick(1'($urandom_range(0, 1)), int'($urandom_range(0, 639)),
                           int'($urandom_range(0, 519)));
            end else begin
                for (int k = 0; k < 6; k++) begin
                    int s = int'($urandom_range(0, NB - 1));
                    pix((m_x[s] + int'($urandom_range(0, 10)) - 2) & 1023,
                        (m_y[s] + int'($urandom_range(0, 29)) - 2) & 1023);
                end
                pix_flush();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
